// File: rtl/calc_seq_core.sv
// Sequential BCD calculator: converts two BCD operands to binary, then add/sub/mul/div.
// Latency 1+DIGITS+E cycles from start (E=1 add/sub/error, OP_W mul/div); start ignored while busy.
module calc_seq_core #(
    parameter int DIGITS = 4,
    parameter int OP_W   = 14,
    parameter int RES_W  = 2*OP_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [4*DIGITS-1:0]          reg_num1,
    input  logic [4*DIGITS-1:0]          reg_num2,
    input  logic [$clog2(DIGITS+1)-1:0]  cnt1,
    input  logic [$clog2(DIGITS+1)-1:0]  cnt2,
    input  logic [7:0]                   sym,
    output logic                         busy,
    output logic                         done,
    output logic [RES_W-1:0]             result,
    output logic                         neg,
    output logic                         err
);
    localparam int CNT_W = $clog2(DIGITS+1);
    localparam int EX_W  = $clog2(OP_W+1);
    localparam logic [CNT_W-1:0] DIG_MAX  = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGITS-1);
    localparam logic [EX_W-1:0]  EX_LAST  = EX_W'(OP_W-1);

    typedef enum logic [1:0] {IDLE, CONV, EXEC, DONE} state_t;
    state_t state_q, state_d;

    logic [4*DIGITS-1:0] num1_q, num2_q;
    logic [CNT_W-1:0]    cnt1_q, cnt2_q, dig_q;
    logic [7:0]          sym_q;
    logic [EX_W-1:0]     ex_q;
    logic [OP_W-1:0]     key1_q, key2_q, rem_q;
    logic                bcd_err_q;
    logic [RES_W-1:0]    prod_q, mcand_q;
    logic [RES_W-1:0]    result_q;
    logic                neg_q, err_q;

    // Current digit of each operand; digits beyond the valid count read as 0.
    logic [3:0] nib1, nib2, d1, d2;
    logic       vld1, vld2, bad1, bad2;
    always_comb begin
        nib1 = '0;
        nib2 = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q == CNT_W'(i)) begin
                nib1 = num1_q[4*i +: 4];
                nib2 = num2_q[4*i +: 4];
            end
        end
    end
    assign vld1 = dig_q < cnt1_q;
    assign vld2 = dig_q < cnt2_q;
    assign d1   = vld1 ? nib1 : 4'd0;
    assign d2   = vld2 ? nib2 : 4'd0;
    assign bad1 = vld1 && (nib1 > 4'd9);
    assign bad2 = vld2 && (nib2 > 4'd9);

    logic [OP_W-1:0] h1, h2;
    assign h1 = key1_q * OP_W'(10) + OP_W'(d1);
    assign h2 = key2_q * OP_W'(10) + OP_W'(d2);

    logic op_add, op_sub, op_mul, op_div, ex_err, ex_last;
    assign op_add  = sym_q == 8'h61;
    assign op_sub  = sym_q == 8'h62;
    assign op_mul  = sym_q == 8'h63;
    assign op_div  = sym_q == 8'h64;
    assign ex_err  = bcd_err_q || !(op_add || op_sub || op_mul || op_div)
                     || (op_div && key2_q == '0);
    assign ex_last = ex_err || op_add || op_sub || (ex_q == EX_LAST);

    logic [RES_W-1:0] prod_nxt;
    assign prod_nxt = prod_q + (key2_q[0] ? mcand_q : '0);

    // Restoring division: quotient bits shift into key1_q as the dividend shifts out.
    logic [OP_W:0]   trial_sh, trial_sub;
    logic            fits;
    logic [OP_W-1:0] rem_nxt, quo_nxt;
    assign trial_sh  = {rem_q, key1_q[OP_W-1]};
    assign trial_sub = trial_sh - {1'b0, key2_q};
    assign fits      = ~trial_sub[OP_W];
    assign rem_nxt   = fits ? trial_sub[OP_W-1:0] : trial_sh[OP_W-1:0];
    assign quo_nxt   = {key1_q[OP_W-2:0], fits};

    logic [OP_W:0]    sum;
    logic [OP_W-1:0]  diff;
    logic             lt;
    logic [RES_W-1:0] res_fin;
    logic             neg_fin, err_fin;
    assign sum  = {1'b0, key1_q} + {1'b0, key2_q};
    assign lt   = key1_q < key2_q;
    assign diff = lt ? (key2_q - key1_q) : (key1_q - key2_q);

    always_comb begin
        res_fin = '0;
        neg_fin = 1'b0;
        err_fin = 1'b0;
        if (ex_err) begin
            err_fin = 1'b1;
        end else if (op_add) begin
            res_fin = RES_W'(sum);
        end else if (op_sub) begin
            res_fin = RES_W'(diff);
            neg_fin = lt;
        end else if (op_mul) begin
            res_fin = prod_nxt;
        end else begin
            res_fin = RES_W'({rem_nxt, quo_nxt});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (dig_q == '0) state_d = EXEC;
            EXEC:    if (ex_last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = state_q != IDLE;
        done = state_q == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num1_q    <= '0;
            num2_q    <= '0;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            sym_q     <= '0;
            dig_q     <= '0;
            ex_q      <= '0;
            key1_q    <= '0;
            key2_q    <= '0;
            rem_q     <= '0;
            bcd_err_q <= 1'b0;
            prod_q    <= '0;
            mcand_q   <= '0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    num1_q    <= reg_num1;
                    num2_q    <= reg_num2;
                    cnt1_q    <= (cnt1 > DIG_MAX) ? DIG_MAX : cnt1;
                    cnt2_q    <= (cnt2 > DIG_MAX) ? DIG_MAX : cnt2;
                    sym_q     <= sym;
                    dig_q     <= DIG_LAST;
                    ex_q      <= '0;
                    key1_q    <= '0;
                    key2_q    <= '0;
                    bcd_err_q <= 1'b0;
                end
                CONV: begin
                    key1_q    <= h1;
                    key2_q    <= h2;
                    bcd_err_q <= bcd_err_q | bad1 | bad2;
                    dig_q     <= dig_q - CNT_W'(1);
                    mcand_q   <= RES_W'(h1);
                    prod_q    <= '0;
                    rem_q     <= '0;
                end
                EXEC: begin
                    ex_q    <= ex_q + EX_W'(1);
                    prod_q  <= prod_nxt;
                    mcand_q <= mcand_q << 1;
                    if (op_mul) key2_q <= key2_q >> 1;
                    if (op_div) begin
                        rem_q  <= rem_nxt;
                        key1_q <= quo_nxt;
                    end
                    if (ex_last) begin
                        result_q <= res_fin;
                        neg_q    <= neg_fin;
                        err_q    <= err_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign neg    = neg_q;
    assign err    = err_q;
endmodule

// File: tb/tb_calc_seq_core.sv
// Bench for calc_seq_core: directed vector table, random ops vs arithmetic model, control corner cases.
module tb_calc_seq_core;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] reg_num1, reg_num2;
    logic [2:0]  cnt1, cnt2;
    logic [7:0]  sym;
    logic        busy, done, neg, err;
    logic [27:0] result;

    int total = 0;
    int bad   = 0;

    calc_seq_core #(.DIGITS(4), .OP_W(14), .RES_W(28)) dut (
        .clk(clk), .rst(rst), .start(start),
        .reg_num1(reg_num1), .reg_num2(reg_num2),
        .cnt1(cnt1), .cnt2(cnt2), .sym(sym),
        .busy(busy), .done(done), .result(result), .neg(neg), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n1, n2;
        logic [2:0]  c1, c2;
        logic [7:0]  s;
        longint      res;
        bit          ng, er;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    function automatic longint bcd_val(input logic [15:0] n, input int c, output bit is_bad);
        longint v;
        int nd, d;
        v = 0;
        is_bad = 1'b0;
        nd = (c > 4) ? 4 : c;
        for (int i = nd - 1; i >= 0; i--) begin
            d = int'((n >> (4*i)) & 16'hF);
            if (d > 9) is_bad = 1'b1;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic void model(input logic [15:0] n1, n2, input logic [2:0] c1, c2,
                                  input logic [7:0] s, output longint res, output bit ng,
                                  output bit er, output int lat);
        longint a, b;
        bit b1, b2;
        a = bcd_val(n1, int'(c1), b1);
        b = bcd_val(n2, int'(c2), b2);
        res = 0;
        ng  = 1'b0;
        er  = b1 || b2 || (s < 8'h61) || (s > 8'h64) || (s == 8'h64 && b == 0);
        lat = (er || s == 8'h61 || s == 8'h62) ? 5 : 18;
        if (!er) begin
            case (s)
                8'h61: res = a + b;
                8'h62: begin ng = a < b; res = ng ? b - a : a - b; end
                8'h63: res = a * b;
                default: res = (a % b) * 16384 + a / b;
            endcase
        end
    endfunction

    // Issues one op, scrambles inputs afterwards, measures edges from the accepting edge to done.
    task automatic run_op(input string nm, input logic [15:0] n1, n2, input logic [2:0] c1, c2,
                          input logic [7:0] s, input longint e_res, input bit e_ng, e_er,
                          input int e_lat);
        int lat;
        logic [27:0] r;
        logic ng, er;
        lat = -1;
        r   = '0;
        ng  = 1'b0;
        er  = 1'b0;
        @(negedge clk);
        reg_num1 = n1; reg_num2 = n2; cnt1 = c1; cnt2 = c2; sym = s; start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        reg_num1 = 16'($urandom);
        reg_num2 = 16'($urandom);
        cnt1     = 3'($urandom);
        cnt2     = 3'($urandom);
        sym      = 8'($urandom_range(8'h61, 8'h64));
        chk({nm, " busy"}, busy, 1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k; r = result; ng = neg; er = err;
                break;
            end
        end
        chk({nm, " latency"}, lat, e_lat);
        chk({nm, " result"}, r, e_res);
        chk({nm, " neg"}, ng, e_ng);
        chk({nm, " err"}, er, e_er);
        if (lat > 0) begin
            @(posedge clk); #1;
            chk({nm, " done one cycle"}, done, 0);
            chk({nm, " result hold"}, result, r);
        end
    endtask

    vec_t vecs[14];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint e_res;
        bit e_ng, e_er;
        int e_lat, pulses, lat, busy_cnt;
        logic [27:0] r;
        logic [15:0] n1, n2;
        logic [2:0]  c1, c2;
        logic [7:0]  s;

        vecs[0]  = '{16'h0012, 16'h0034, 3'd2, 3'd2, 8'h61, 46,       0, 0, 5};
        vecs[1]  = '{16'h0025, 16'h0100, 3'd2, 3'd3, 8'h62, 75,       1, 0, 5};
        vecs[2]  = '{16'h9999, 16'h9999, 3'd4, 3'd4, 8'h63, 99980001, 0, 0, 18};
        vecs[3]  = '{16'h0100, 16'h0007, 3'd3, 3'd1, 8'h64, 32782,    0, 0, 18};
        vecs[4]  = '{16'h1234, 16'h0000, 3'd4, 3'd4, 8'h64, 0,        0, 1, 5};
        vecs[5]  = '{16'hFF12, 16'h0000, 3'd2, 3'd0, 8'h61, 12,       0, 0, 5};
        vecs[6]  = '{16'h001A, 16'h0001, 3'd2, 3'd1, 8'h61, 0,        0, 1, 5};
        vecs[7]  = '{16'h0012, 16'h0034, 3'd2, 3'd2, 8'h65, 0,        0, 1, 5};
        vecs[8]  = '{16'h1234, 16'h0001, 3'd7, 3'd1, 8'h61, 1235,     0, 0, 5};
        vecs[9]  = '{16'h0500, 16'h0500, 3'd3, 3'd3, 8'h62, 0,        0, 0, 5};
        vecs[10] = '{16'h1234, 16'h00B1, 3'd4, 3'd2, 8'h63, 0,        0, 1, 5};
        vecs[11] = '{16'h9999, 16'h0001, 3'd4, 3'd1, 8'h64, 9999,     0, 0, 18};
        vecs[12] = '{16'h0005, 16'h0009, 3'd1, 3'd1, 8'h64, 81920,    0, 0, 18};
        vecs[13] = '{16'h00F3, 16'h0002, 3'd1, 3'd1, 8'h63, 6,        0, 0, 18};

        rst = 1'b1; start = 1'b0; reg_num1 = '0; reg_num2 = '0; cnt1 = '0; cnt2 = '0; sym = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset neg", neg, 0);
        chk("reset err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].n1, vecs[i].n2, vecs[i].c1, vecs[i].c2,
                   vecs[i].s, vecs[i].res, vecs[i].ng, vecs[i].er, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            n1 = '0;
            n2 = '0;
            for (int d = 0; d < 4; d++) begin
                n1[4*d +: 4] = ($urandom_range(0, 15) < 14) ? 4'($urandom_range(0, 9))
                                                             : 4'($urandom_range(10, 15));
                n2[4*d +: 4] = ($urandom_range(0, 15) < 14) ? 4'($urandom_range(0, 9))
                                                             : 4'($urandom_range(10, 15));
            end
            c1 = 3'($urandom_range(0, 7));
            c2 = 3'($urandom_range(0, 7));
            s  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'(8'h61 + $urandom_range(0, 3));
            model(n1, n2, c1, c2, s, e_res, e_ng, e_er, e_lat);
            run_op($sformatf("rnd%0d", i), n1, n2, c1, c2, s, e_res, e_ng, e_er, e_lat);
        end

        // start pulsed during an in-flight multiply must be ignored
        @(negedge clk);
        reg_num1 = 16'h0012; reg_num2 = 16'h0034; cnt1 = 3'd2; cnt2 = 3'd2; sym = 8'h63;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0; lat = -1; r = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin start = 1'b1; reg_num1 = 16'h0002; sym = 8'h61; end
            if (k == 4) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (lat < 0) begin lat = k; r = result; end
            end
        end
        chk("busy-start pulses", pulses, 1);
        chk("busy-start latency", lat, 18);
        chk("busy-start result", r, 408);

        run_op("pre-reset sub", 16'h0025, 16'h0100, 3'd2, 3'd3, 8'h62, 75, 1, 0, 5);

        // reset mid-multiply, with start held during reset
        @(negedge clk);
        reg_num1 = 16'h9999; reg_num2 = 16'h9999; cnt1 = 3'd4; cnt2 = 3'd4; sym = 8'h63;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; sym = 8'h61;
        @(posedge clk); #1;
        chk("mid-reset busy", busy, 0);
        chk("mid-reset done", done, 0);
        chk("mid-reset result", result, 0);
        chk("mid-reset neg", neg, 0);
        chk("mid-reset err", err, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        pulses = 0; busy_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
            if (busy) busy_cnt++;
        end
        chk("aborted op done pulses", pulses, 0);
        chk("aborted op busy cycles", busy_cnt, 0);
        run_op("post-reset mul", 16'h9999, 16'h9999, 3'd4, 3'd4, 8'h63, 99980001, 0, 0, 18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/calc_seq_core.md
CALC_SEQ_CORE -- requirements
Module: calc_seq_core

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of BCD digits per operand.
REQ-002 The block SHALL have parameter OP_W, default 14, meaning the binary operand width; it must hold 10^DIGITS-1.
REQ-003 The block SHALL have parameter RES_W, default 2*OP_W, meaning the result width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all logic on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: a one-cycle request to begin an operation.
REQ-007 The block SHALL have port reg_num1, input, 4*DIGITS bits: operand 1 in BCD, digit 0 (least significant) at [3:0].
REQ-008 The block SHALL have port reg_num2, input, 4*DIGITS bits: operand 2 in BCD, same layout as reg_num1.
REQ-009 The block SHALL have ports cnt1 and cnt2, input, $clog2(DIGITS+1) bits each: the count of valid digits in each operand.
REQ-010 The block SHALL have port sym, input, 8 bits, encoding the operation: 8'h61 add, 8'h62 subtract, 8'h63 multiply, 8'h64 divide.
REQ-011 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-013 The block SHALL have port result, output, RES_W bits: the binary result.
REQ-014 The block SHALL have port neg, output, 1 bit: high when a subtraction result is negative.
REQ-015 The block SHALL have port err, output, 1 bit: the error flag.

Function
REQ-016 The FSM SHALL use states IDLE, CONV, EXEC and DONE; IDLE->CONV on start, CONV->EXEC after DIGITS cycles, EXEC->DONE when the operation completes, DONE->IDLE unconditionally.
REQ-017 The block SHALL sample reg_num1, reg_num2, cnt1, cnt2 and sym into internal registers in the IDLE cycle where start=1, and later input changes SHALL have no effect.
REQ-018 The block SHALL ignore start while busy=1; busy SHALL be high in CONV, EXEC and DONE.
REQ-019 CONV SHALL do Horner conversion, one digit per cycle per operand in parallel, from digit DIGITS-1 down to 0: acc = acc*10 + d.
REQ-020 During CONV, digits at index >= cnt SHALL be treated as 0 and not checked; cnt > DIGITS SHALL be clamped to DIGITS; cnt = 0 SHALL give operand 0.
REQ-021 Any valid-index nibble greater than 9 SHALL set err.
REQ-022 Add SHALL produce key1+key2, zero-extended, with neg=0.
REQ-023 Subtract SHALL produce |key1-key2|, with neg=1 exactly when key1<key2.
REQ-024 Multiply SHALL be iterative shift-add over exactly OP_W EXEC cycles, producing the full product.
REQ-025 Divide SHALL be restoring division over exactly OP_W EXEC cycles, producing result = {remainder[OP_W-1:0], quotient[OP_W-1:0]}.
REQ-026 Add, subtract and every error case SHALL each take 1 EXEC cycle.
REQ-027 An error SHALL give err=1, result=0 and neg=0; error cases are a divisor of 0, a sym outside 8'h61..8'h64, and a non-BCD digit.
REQ-028 With start accepted at cycle T, done SHALL be high at exactly T+1+DIGITS+E, where E=1 for add, subtract or error and E=OP_W for multiply or divide.
REQ-029 result, neg and err SHALL update only in the DONE cycle and hold until the next DONE or reset.
REQ-030 done SHALL be high in the DONE cycle only; a new start SHALL be accepted in the first IDLE cycle after DONE.

Reset
REQ-031 With rst=1, state SHALL go to IDLE and busy, done, result, neg and err SHALL all be 0 on the next edge.
REQ-032 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse.
REQ-033 A start sampled in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-034 Add: reg_num1=16'h0012, cnt1=2, reg_num2=16'h0034, cnt2=2, sym=8'h61, start at T -> done at T+6, result=46, neg=0, err=0.
REQ-035 Subtract: reg_num1=16'h0025, cnt1=2, reg_num2=16'h0100, cnt2=3, sym=8'h62 -> result=75, neg=1.
REQ-036 Multiply: 16'h9999 x 16'h9999, cnt=4, sym=8'h63 -> done at T+19, result=99980001.
REQ-037 Divide: 100/7 -> result={14'd2,14'd14}=32782; divide 1234/0 -> err=1, result=0, done at T+6.
REQ-038 Masking and error: reg_num1=16'hFF12, cnt1=2 -> operand 12, err=0; reg_num1=16'h001A, cnt1=2 -> err=1; sym=8'h65 -> err=1.
REQ-039 Control: start pulsed while busy -> ignored, single done pulse; rst asserted mid-multiply -> no done pulse, all outputs 0, next start completes normally.
